store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 39 +++
 rtl/store_buffer.sv | 122 ++++++++++++
 tb/tb_store_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: groups the store, load-forward, memory-write and flush
// signals of the store buffer into one bundle.
//   slave  modport : used by store_buffer (drives StoreReady, LoadHit,
//                    LoadHitData, MemWrite, MemAddress, MemWriteData,
//                    FlushDone, Count)
//   master modport : used by the pipeline/memory side driving the requests
//                    (StoreValid/Address/Data, LoadAddress, MemGrant, Flush)
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          StoreValid;
  logic [31:0]   StoreAddress;
  logic [31:0]   StoreData;
  logic          StoreReady;
  logic [31:0]   LoadAddress;
  logic          LoadHit;
  logic [31:0]   LoadHitData;
  logic          MemGrant;
  logic          MemWrite;
  logic [31:0]   MemAddress;
  logic [31:0]   MemWriteData;
  logic          Flush;
  logic          FlushDone;
  logic [CW-1:0] Count;

  modport master (
    output StoreValid, StoreAddress, StoreData, LoadAddress, MemGrant, Flush,
    input  StoreReady, LoadHit, LoadHitData, MemWrite, MemAddress,
           MemWriteData, FlushDone, Count
  );

  modport slave (
    input  StoreValid, StoreAddress, StoreData, LoadAddress, MemGrant, Flush,
    output StoreReady, LoadHit, LoadHitData, MemWrite, MemAddress,
           MemWriteData, FlushDone, Count
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending stores between the MEM stage and
// data memory, with youngest-match load forwarding and a flush/drain FSM.
//   Clk   : single clock, all state updates on posedge
//   Reset : synchronous active-high reset
//   bus   : store_buffer_if.slave
//           StoreValid/StoreAddress/StoreData in, StoreReady out (push side)
//           LoadAddress in, LoadHit/LoadHitData out (forwarding)
//           MemGrant in, MemWrite/MemAddress/MemWriteData out (drain side)
//           Flush in, FlushDone out (one-cycle completion pulse)
//           Count out (number of valid entries)
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  store_buffer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t        r_state;
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_flush_done;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [PW:0]   w_count_next;
  logic [PW-1:0] w_idx;
  logic          w_hit;
  logic [31:0]   w_hit_data;

  // Ready depends on registered state only, never on MemGrant.
  assign w_ready      = (r_count < FULL) && (r_state != FLUSH);
  assign w_push       = bus.StoreValid && w_ready;
  assign w_pop        = (r_count != '0) && bus.MemGrant;
  assign w_count_next = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

  assign bus.StoreReady   = w_ready;
  assign bus.MemWrite     = w_pop;
  assign bus.MemAddress   = (r_count != '0) ? r_addr[r_head] : '0;
  assign bus.MemWriteData = (r_count != '0) ? r_data[r_head] : '0;
  assign bus.FlushDone    = r_flush_done;
  assign bus.Count        = r_count;
  assign bus.LoadHit      = w_hit;
  assign bus.LoadHitData  = w_hit_data;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  // Only registered entries are searched, so a same-cycle push is invisible.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_idx      = r_head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (((PW+1)'(k) < r_count) && (r_addr[w_idx] == bus.LoadAddress)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_idx];
      end
    end
  end

  // Entry storage needs no reset: validity is tracked by head/count.
  always_ff @(posedge Clk) begin
    if (!Reset && w_push) begin
      r_addr[r_tail] <= bus.StoreAddress;
      r_data[r_tail] <= bus.StoreData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      r_count      <= w_count_next;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case (r_state)
        IDLE: begin
          if (bus.Flush) begin
            // A push accepted alongside the flush must drain first.
            if (w_push) r_state <= FLUSH;
            else        r_flush_done <= 1'b1;
          end else if (w_push) begin
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.Flush) begin
            // Last entry leaving on the flush edge completes the flush at once.
            if (w_count_next == '0) begin
              r_state      <= IDLE;
              r_flush_done <= 1'b1;
            end else begin
              r_state <= FLUSH;
            end
          end else if (w_count_next == '0) begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if (w_count_next == '0) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH=4).
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns later.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  store_buffer_if #(.DEPTH(4)) bus ();

  store_buffer #(.DEPTH(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    bus.StoreValid   = 1'b1;
    bus.StoreAddress = a;
    bus.StoreData    = d;
    cyc();
    bus.StoreValid   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.StoreValid   = 1'b0;
    bus.StoreAddress = '0;
    bus.StoreData    = '0;
    bus.LoadAddress  = '0;
    bus.MemGrant     = 1'b0;
    bus.Flush        = 1'b0;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_ready", 32'(bus.StoreReady), 1);
    chk("rst_memwrite", 32'(bus.MemWrite), 0);
    chk("rst_loadhit", 32'(bus.LoadHit), 0);
    chk("rst_memaddr", bus.MemAddress, 0);

    // Fill to DEPTH with MemGrant low; fifth push ignored
    bus.StoreValid = 1'b1; bus.StoreAddress = 10; bus.StoreData = 111;
    #1 chk("s1_ready_empty", 32'(bus.StoreReady), 1);
    cyc();
    bus.StoreAddress = 11; bus.StoreData = 222; cyc();
    bus.StoreAddress = 12; bus.StoreData = 333; cyc();
    bus.StoreAddress = 13; bus.StoreData = 444; cyc();
    bus.StoreAddress = 14; bus.StoreData = 555;
    #1;
    chk("s1_count_full", 32'(bus.Count), 4);
    chk("s1_ready_full", 32'(bus.StoreReady), 0);
    chk("s1_nowrite", 32'(bus.MemWrite), 0);
    cyc();
    #1;
    chk("s1_count_held", 32'(bus.Count), 4);
    chk("s1_head_addr", bus.MemAddress, 10);
    // Full with a same-cycle pop still refuses the push
    bus.MemGrant = 1'b1;
    #1;
    chk("s1_full_pop_ready", 32'(bus.StoreReady), 0);
    chk("s1_pop_write", 32'(bus.MemWrite), 1);
    chk("s1_pop_data0", bus.MemWriteData, 111);
    bus.StoreValid = 1'b0;
    cyc();
    chk("s1_count3", 32'(bus.Count), 3);
    chk("s1_pop_addr1", bus.MemAddress, 11);
    chk("s1_pop_data1", bus.MemWriteData, 222);
    cyc();
    chk("s1_pop_data2", bus.MemWriteData, 333);
    cyc();
    chk("s1_pop_data3", bus.MemWriteData, 444);
    cyc();
    bus.MemGrant = 1'b0;
    #1;
    chk("s1_empty", 32'(bus.Count), 0);
    chk("s1_empty_write", 32'(bus.MemWrite), 0);
    chk("s1_empty_addr", bus.MemAddress, 0);
    chk("s1_empty_ready", 32'(bus.StoreReady), 1);

    // Youngest-match forwarding
    bus.LoadAddress = 20;
    push(20, 5);
    push(20, 9);
    #1;
    chk("s2_count", 32'(bus.Count), 2);
    chk("s2_hit", 32'(bus.LoadHit), 1);
    chk("s2_hitdata", bus.LoadHitData, 9);
    bus.LoadAddress = 21;
    #1;
    chk("s2_miss", 32'(bus.LoadHit), 0);
    chk("s2_missdata", bus.LoadHitData, 0);
    bus.StoreValid = 1'b1; bus.StoreAddress = 21; bus.StoreData = 77;
    #1 chk("s2_samecycle_push_invisible", 32'(bus.LoadHit), 0);
    cyc();
    bus.StoreValid = 1'b0;
    #1;
    chk("s2_hit_new", 32'(bus.LoadHit), 1);
    chk("s2_hitdata_new", bus.LoadHitData, 77);
    chk("s2_count3", 32'(bus.Count), 3);

    // Simultaneous push and pop at Count 3, tail wraps
    bus.StoreValid = 1'b1; bus.StoreAddress = 30; bus.StoreData = 7;
    bus.MemGrant = 1'b1;
    #1;
    chk("s3_write", 32'(bus.MemWrite), 1);
    chk("s3_head_addr", bus.MemAddress, 20);
    chk("s3_head_data", bus.MemWriteData, 5);
    chk("s3_ready", 32'(bus.StoreReady), 1);
    cyc();
    bus.StoreAddress = 31; bus.StoreData = 8;
    #1;
    chk("s3_count_pp1", 32'(bus.Count), 3);
    chk("s3_head_data2", bus.MemWriteData, 9);
    cyc();
    bus.StoreValid = 1'b0;
    #1;
    chk("s3_count_pp2", 32'(bus.Count), 3);
    chk("s3_head_addr3", bus.MemAddress, 21);
    chk("s3_head_data3", bus.MemWriteData, 77);
    cyc();
    bus.LoadAddress = 30;
    #1;
    chk("s3_head_addr4", bus.MemAddress, 30);
    chk("s3_hit_popping_head", 32'(bus.LoadHit), 1);
    chk("s3_hitdata_popping_head", bus.LoadHitData, 7);
    cyc();
    chk("s3_wrapped_addr", bus.MemAddress, 31);
    chk("s3_wrapped_data", bus.MemWriteData, 8);
    chk("s3_popped_miss", 32'(bus.LoadHit), 0);
    cyc();
    bus.MemGrant = 1'b0;
    #1 chk("s3_empty", 32'(bus.Count), 0);

    // Flush with two entries
    push(40, 1);
    push(41, 2);
    bus.Flush = 1'b1; bus.MemGrant = 1'b1;
    #1;
    chk("s4_write0", 32'(bus.MemWrite), 1);
    chk("s4_addr0", bus.MemAddress, 40);
    chk("s4_done_early", 32'(bus.FlushDone), 0);
    cyc();
    bus.Flush = 1'b0;
    bus.StoreValid = 1'b1; bus.StoreAddress = 50; bus.StoreData = 50;
    #1;
    chk("s4_ready_drain", 32'(bus.StoreReady), 0);
    chk("s4_count1", 32'(bus.Count), 1);
    chk("s4_addr1", bus.MemAddress, 41);
    chk("s4_done_mid", 32'(bus.FlushDone), 0);
    cyc();
    bus.StoreValid = 1'b0;
    #1;
    chk("s4_count0", 32'(bus.Count), 0);
    chk("s4_done", 32'(bus.FlushDone), 1);
    chk("s4_ready_idle", 32'(bus.StoreReady), 1);
    chk("s4_nowrite", 32'(bus.MemWrite), 0);
    cyc();
    chk("s4_done_once", 32'(bus.FlushDone), 0);
    bus.MemGrant = 1'b0;

    // Flush while idle
    bus.Flush = 1'b1;
    #1 chk("s4_idle_done_early", 32'(bus.FlushDone), 0);
    cyc();
    bus.Flush = 1'b0;
    #1;
    chk("s4_idle_done", 32'(bus.FlushDone), 1);
    chk("s4_idle_count", 32'(bus.Count), 0);
    cyc();
    chk("s4_idle_done_once", 32'(bus.FlushDone), 0);

    // Push and flush in the same idle cycle: flush covers that entry
    bus.StoreValid = 1'b1; bus.StoreAddress = 70; bus.StoreData = 3;
    bus.Flush = 1'b1;
    cyc();
    bus.StoreValid = 1'b0; bus.Flush = 1'b0;
    #1;
    chk("s4_pf_count", 32'(bus.Count), 1);
    chk("s4_pf_ready", 32'(bus.StoreReady), 0);
    chk("s4_pf_done_early", 32'(bus.FlushDone), 0);
    bus.MemGrant = 1'b1;
    cyc();
    bus.MemGrant = 1'b0;
    #1;
    chk("s4_pf_count0", 32'(bus.Count), 0);
    chk("s4_pf_done", 32'(bus.FlushDone), 1);
    cyc();
    chk("s4_pf_done_once", 32'(bus.FlushDone), 0);

    // Reset in the middle of a flush
    push(60, 1);
    push(61, 2);
    bus.Flush = 1'b1;
    cyc();
    bus.Flush = 1'b0;
    #1;
    chk("s5_flush_ready", 32'(bus.StoreReady), 0);
    chk("s5_flush_count", 32'(bus.Count), 2);
    rst = 1'b1; bus.MemGrant = 1'b1;
    cyc();
    rst = 1'b0; bus.LoadAddress = 60;
    #1;
    chk("s5_count", 32'(bus.Count), 0);
    chk("s5_memwrite", 32'(bus.MemWrite), 0);
    chk("s5_done", 32'(bus.FlushDone), 0);
    chk("s5_hit60", 32'(bus.LoadHit), 0);
    chk("s5_ready", 32'(bus.StoreReady), 1);
    bus.LoadAddress = 61;
    #1 chk("s5_hit61", 32'(bus.LoadHit), 0);
    cyc();
    chk("s5_done_after", 32'(bus.FlushDone), 0);
    chk("s5_count_after", 32'(bus.Count), 0);
    bus.MemGrant = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
